// File: rtl/tx_bd_framer.sv
// Transmit framer: alternating preamble, one repeated boundary symbol, then payload
// bits from an upstream source, one symbol per sym_en strobe.
module tx_bd_framer #(
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int LEN_WIDTH        = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sym_en,
  input  logic [MAX_WINDOW_WIDTH-1:0] TX_PRE_LEN,
  input  logic [LEN_WIDTH-1:0]        TX_PAYLOAD_LEN,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        data_in,
  input  logic                        data_vld,
  output logic                        data_rdy,
  output logic                        BPSK,
  output logic                        tx_vld,
  output logic                        HDR_Pos,
  output logic                        busy,
  output logic                        done,
  output logic                        underflow,
  output logic                        cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    BD   = 2'd2,
    PAY  = 2'd3
  } state_t;

  state_t                      state_r;
  logic [MAX_WINDOW_WIDTH-1:0] pre_len_r;
  logic [MAX_WINDOW_WIDTH-1:0] pre_cnt_r;
  logic [LEN_WIDTH-1:0]        pay_len_r;
  logic [LEN_WIDTH-1:0]        pay_cnt_r;
  logic                        cfg_ok_s;
  logic                        pre_last_s;
  logic                        pay_last_s;

  // Config check and last-symbol detection; full-width compares so counters never wrap.
  always_comb begin
    cfg_ok_s   = (TX_PRE_LEN > MAX_WINDOW_WIDTH'(1'b1)) && (TX_PAYLOAD_LEN != LEN_WIDTH'(1'b0));
    pre_last_s = (pre_cnt_r == (pre_len_r - MAX_WINDOW_WIDTH'(1'b1)));
    pay_last_s = (pay_cnt_r == (pay_len_r - LEN_WIDTH'(1'b1)));
    data_rdy   = (state_r == PAY) && sym_en;
  end

  // Frame sequencer with registered symbol and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pre_len_r <= MAX_WINDOW_WIDTH'(1'b0);
      pre_cnt_r <= MAX_WINDOW_WIDTH'(1'b0);
      pay_len_r <= LEN_WIDTH'(1'b0);
      pay_cnt_r <= LEN_WIDTH'(1'b0);
      BPSK      <= 1'b0;
      tx_vld    <= 1'b0;
      HDR_Pos   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underflow <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done      <= 1'b0;
      underflow <= 1'b0;
      cfg_err   <= 1'b0;
      if (abort) begin
        state_r   <= IDLE;
        pre_cnt_r <= MAX_WINDOW_WIDTH'(1'b0);
        pay_cnt_r <= LEN_WIDTH'(1'b0);
        BPSK      <= 1'b0;
        tx_vld    <= 1'b0;
        HDR_Pos   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (sym_en) begin
              BPSK    <= 1'b0;
              tx_vld  <= 1'b0;
              HDR_Pos <= 1'b0;
            end
            if (start) begin
              if (cfg_ok_s) begin
                pre_len_r <= TX_PRE_LEN;
                pay_len_r <= TX_PAYLOAD_LEN;
                pre_cnt_r <= MAX_WINDOW_WIDTH'(1'b0);
                pay_cnt_r <= LEN_WIDTH'(1'b0);
                state_r   <= PRE;
                busy      <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          PRE: begin
            if (sym_en) begin
              BPSK      <= pre_cnt_r[0];
              tx_vld    <= 1'b1;
              HDR_Pos   <= 1'b1;
              pre_cnt_r <= pre_cnt_r + MAX_WINDOW_WIDTH'(1'b1);
              if (pre_last_s) begin
                state_r <= BD;
              end
            end
          end
          BD: begin
            // BPSK is left untouched: the missing transition marks the header.
            if (sym_en) begin
              tx_vld  <= 1'b1;
              HDR_Pos <= 1'b0;
              state_r <= PAY;
            end
          end
          PAY: begin
            if (sym_en) begin
              tx_vld  <= 1'b1;
              HDR_Pos <= 1'b0;
              if (data_vld) begin
                BPSK      <= data_in;
                pay_cnt_r <= pay_cnt_r + LEN_WIDTH'(1'b1);
                if (pay_last_s) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
                end
              end else begin
                underflow <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            BPSK    <= 1'b0;
            tx_vld  <= 1'b0;
            HDR_Pos <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tx_bd_framer.md
Name: tx_bd_framer

Overview:
- Transmit-side framer that generates the BPSK symbol stream the receive boundary detector expects.
- Frame layout: an alternating preamble (0,1,0,1,...), then one boundary symbol that repeats the last preamble bit (the missing transition marks the header), then payload bits pulled from an upstream bit source.
- Sits between the packet bit source and the BPSK modulator; one output symbol is produced per sym_en strobe.

Parameters:
- MAX_WINDOW_WIDTH, 8, width of the preamble-length configuration and preamble counter.
- LEN_WIDTH, 12, width of the payload-length configuration and payload counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sym_en  input  1  symbol-rate strobe; state and symbol outputs advance only on cycles where sym_en=1.
- TX_PRE_LEN  input  MAX_WINDOW_WIDTH  preamble length P in symbols; latched at start.
- TX_PAYLOAD_LEN  input  LEN_WIDTH  payload length L in bits; latched at start.
- start  input  1  frame request; honoured only in IDLE.
- abort  input  1  synchronous frame abort.
- data_in  input  1  payload bit.
- data_vld  input  1  payload bit valid.
- data_rdy  output  1  combinational: (state==PAY) & sym_en.
- BPSK  output  1  registered symbol bit to the modulator.
- tx_vld  output  1  registered; BPSK carries a frame symbol.
- HDR_Pos  output  1  registered; 1 while a preamble symbol is on BPSK.
- busy  output  1  registered; 1 in PRE, BD and PAY.
- done  output  1  one-cycle pulse when the last payload bit is registered onto BPSK.
- underflow  output  1  one-cycle pulse on a missed payload bit.
- cfg_err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state=IDLE; BPSK, tx_vld, HDR_Pos, busy, done, underflow and cfg_err are all 0; counters are 0. Reset mid-frame has the same effect within one cycle.
- States: IDLE, PRE, BD, PAY.
- IDLE:
  - start=1 with P>=2 and L>=1: latch P and L, clear counters, go to PRE, busy<=1.
  - start=1 with P<2 or L=0: stay in IDLE, cfg_err pulses.
  - sym_en=1: BPSK<=0, tx_vld<=0, HDR_Pos<=0.
  - A sym_en coinciding with the accepted start is not used to emit a symbol.
- PRE:
  - On each sym_en: BPSK<=pre_cnt[0], tx_vld<=1, HDR_Pos<=1, pre_cnt++.
  - After the P-th preamble symbol, go to BD.
- BD:
  - On sym_en: BPSK holds its value (the repeat, equal to (P-1)&1), HDR_Pos<=0, tx_vld<=1.
  - Then go to PAY.
- PAY, on sym_en:
  - data_vld=1: transfer occurs; BPSK<=data_in, pay_cnt++.
  - When pay_cnt reaches L: done pulses in the next cycle (alongside the last bit), state goes to IDLE, busy<=0. tx_vld stays 1 until the next sym_en.
  - data_vld=0: BPSK holds its previous value, pay_cnt does not advance, underflow pulses, and the frame continues.
- start while busy: ignored, with no cfg_err.
- abort (any state, highest priority after rst):
  - Go to IDLE immediately: BPSK<=0, tx_vld<=0, HDR_Pos<=0, busy<=0.
  - No done pulse.
  - abort in the same cycle as start: abort wins and no frame starts.
- Latency: the symbol is visible on BPSK one cycle after its sym_en.
- Total frame length is P+1+L symbols, excluding underflow holds.
- Counters must not wrap. Limits are P<=2^MAX_WINDOW_WIDTH-1 and L<=2^LEN_WIDTH-1; the compare uses the full width.
- sym_en can be held at 1 continuously (one symbol per clk).

Test Plan:
- P=8, L=4, data 1,0,1,1, sym_en tied high, data_vld high -> BPSK sequence 0,1,0,1,0,1,0,1 | 1 | 1,0,1,1. HDR_Pos=1 for the first 8 symbols. done pulses with the final 1. The frame fed to the receive detector yields BD_sgn=1.
- P=7, L=2, sym_en every 4th cycle -> preamble 0,1,0,1,0,1,0, boundary 0. Outputs change only the cycle after each strobe. Total 10 symbols over 40 cycles.
- P=8, L=3, data_vld low for the 2nd payload strobe -> underflow pulses once, the symbol is repeated, and 3 payload bits are still delivered. done arrives one strobe later than nominal.
- start with P=1 or L=0 -> cfg_err pulses, busy stays 0, tx_vld stays 0.
- Abort during PRE at symbol 3, then restart with P=4, L=1 -> tx_vld drops the next cycle with no done. The new frame begins cleanly with 0,1,0,1,1,d.
- rst asserted mid-PAY -> all outputs 0 the next cycle. start during busy produces no effect.
